// File: rtl/xor_map_engine.sv
// xor_map_engine: one-element-per-cycle op(A,B) map over an external RF.
// Define XOR_MAP_ROTL_EN to make op 3 rotate-left (otherwise op 3 is XOR).
module xor_map_engine #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          cond_flag,
  input  logic [AW-1:0] origin,
  input  logic [AW-1:0] modifier,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [W-1:0]  rf_rdata_a,
  input  logic [W-1:0]  rf_rdata_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [AW-1:0] r_org;
  logic [AW-1:0] r_mod;
  logic [AW-1:0] r_k;
  logic [LW-1:0] r_len;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic          r_fwd_a;
  logic          r_fwd_b;
  logic [W-1:0]  r_fwd_d;

  logic          w_accept;
  logic          w_skip;
  logic          w_last;
  logic [AW-1:0] w_raddr_a;
  logic [AW-1:0] w_raddr_b;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_res;

  assign w_accept  = start && (r_state == S_IDLE);
  assign w_skip    = !cond_flag || (length == '0);
  assign w_last    = (LW'(r_k) == (r_len - LW'(1)));
  assign w_raddr_a = r_org + r_k;
  assign w_raddr_b = r_mod + r_k;

  // RF reads are read-before-write: patch in the word written alongside the read
  assign w_a = r_fwd_a ? r_fwd_d : rf_rdata_a;
  assign w_b = r_fwd_b ? r_fwd_d : rf_rdata_b;

`ifdef XOR_MAP_ROTL_EN
  localparam int SW = $clog2(W);
  logic [2*W-1:0] w_rot2;
  logic [W-1:0]   w_rot;
  assign w_rot2 = {w_a, w_a} << w_b[SW-1:0];
  assign w_rot  = w_rot2[2*W-1:W];
`endif

  always_comb begin
    w_res = w_a ^ w_b;
    case (r_op)
      2'd1: w_res = w_a + w_b;
      2'd2: w_res = w_a - w_b;
`ifdef XOR_MAP_ROTL_EN
      2'd3: w_res = w_rot;
`endif
      default: w_res = w_a ^ w_b;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_skip ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_org   <= '0;
      r_mod   <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_fwd_a <= 1'b0;
      r_fwd_b <= 1'b0;
      r_fwd_d <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= op;
        r_org <= origin;
        r_mod <= modifier;
        r_len <= length;
        r_k   <= '0;
      end else if (r_state == S_RUN) begin
        r_k <= r_k + AW'(1);
      end
      r_we    <= (r_state == S_RUN);
      r_waddr <= w_raddr_a;
      r_fwd_a <= r_we && (w_raddr_a == r_waddr);
      r_fwd_b <= r_we && (w_raddr_b == r_waddr);
      r_fwd_d <= w_res;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign rf_raddr_a = w_raddr_a;
  assign rf_raddr_b = w_raddr_b;
  assign rf_we      = r_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_we ? w_res : '0;

endmodule

// File: tb/tb_xor_map_engine.sv
// Scoreboard bench for xor_map_engine with a behavioural register file.
// Expected writes come from a sequential reference loop over a shadow array.
module tb_xor_map_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic        cond_flag = 1'b0;
  logic [5:0]  origin = '0;
  logic [5:0]  modifier = '0;
  logic [6:0]  length = '0;
  logic        busy, done;
  logic [5:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;

  logic [31:0] rf [64];
  logic [31:0] mdl [64];
  logic [37:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_map_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .cond_flag(cond_flag), .origin(origin), .modifier(modifier),
    .length(length), .busy(busy), .done(done),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always @(posedge clk) begin
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      logic [37:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   rf_waddr, rf_wdata, e[37:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] f_op(input logic [1:0] o,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] r;
    case (o)
      2'd1: r = a + b;
      2'd2: r = a - b;
`ifdef XOR_MAP_ROTL_EN
      2'd3: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], r[31]};
      end
`endif
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic load(input logic [5:0] a, input logic [31:0] v);
    rf[a]  = v;
    mdl[a] = v;
  endtask

  task automatic model_cmd(input logic [1:0] o, input logic c,
                           input logic [5:0] org, input logic [5:0] mdf,
                           input int len);
    logic [5:0] a, b;
    logic [31:0] d;
    if (c) begin
      for (int k = 0; k < len; k++) begin
        a = org + 6'(k);
        b = mdf + 6'(k);
        d = f_op(o, mdl[a], mdl[b]);
        mdl[a] = d;
        exp_q.push_back({a, d});
      end
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 64; i++) if (rf[i] !== mdl[i]) n++;
    return n;
  endfunction

  task automatic run_cmd(input logic [1:0] o, input logic c,
                         input logic [5:0] org, input logic [5:0] mdf,
                         input logic [6:0] len, input int poke_at,
                         output int cyc);
    @(negedge clk);
    op = o; cond_flag = c; origin = org; modifier = mdf; length = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == poke_at) begin
        op = 2'd1; cond_flag = 1'b1; origin = 6'd50; modifier = 6'd51;
        length = 7'd5; start = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, rf_we, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b ra=%0d rb=%0d wa=%0d wd=%h want all zero",
               busy, done, rf_we, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_xor();
    int cyc, n;
    load(0, 1); load(1, 2); load(2, 3); load(3, 4);
    for (int i = 8; i < 12; i++) load(6'(i), 32'hF);
    model_cmd(2'd0, 1'b1, 6'd0, 6'd8, 4);
    run_cmd(2'd0, 1'b1, 6'd0, 6'd8, 7'd4, 0, cyc);
    checks++;
    if (cyc !== 6) begin
      failures++;
      $display("FAIL xor_done_latency got %0d want 6", cyc);
    end
    @(negedge clk);
    checks++;
    if ({rf[0], rf[1], rf[2], rf[3]} !== {32'hE, 32'hD, 32'hC, 32'hB}) begin
      failures++;
      $display("FAIL xor_result got %h %h %h %h want e d c b", rf[0], rf[1], rf[2], rf[3]);
    end
    n = mem_diff();
    checks++;
    if (n !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL xor_mem diff=%0d pending=%0d want 0 0", n, exp_q.size());
    end
  endtask

  task automatic test_overlap();
    int cyc;
    load(0, 5); load(1, 1); load(2, 1); load(3, 1);
    model_cmd(2'd0, 1'b1, 6'd1, 6'd0, 3);
    run_cmd(2'd0, 1'b1, 6'd1, 6'd0, 7'd3, 0, cyc);
    @(negedge clk);
    checks++;
    if ({rf[1], rf[2], rf[3]} !== {32'h4, 32'h5, 32'h4} || cyc !== 5) begin
      failures++;
      $display("FAIL overlap got %h %h %h cyc=%0d want 4 5 4 cyc=5", rf[1], rf[2], rf[3], cyc);
    end
  endtask

  task automatic test_add_wrap();
    int cyc, n;
    load(62, 32'hFFFFFFFF); load(0, 1); load(63, 32'h10); load(1, 32'h22);
    model_cmd(2'd1, 1'b1, 6'd62, 6'd0, 3);
    run_cmd(2'd1, 1'b1, 6'd62, 6'd0, 7'd3, 0, cyc);
    @(negedge clk);
    checks++;
    if (rf[62] !== 32'h0) begin
      failures++;
      $display("FAIL add_wrap rf62 got %h want 00000000", rf[62]);
    end
    n = mem_diff();
    checks++;
    if (n !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL add_wrap_mem diff=%0d pending=%0d want 0 0", n, exp_q.size());
    end
  endtask

  task automatic test_skip();
    int cyc, n;
    run_cmd(2'd0, 1'b0, 6'd4, 6'd9, 7'd6, 0, cyc);
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("FAIL skip_cond latency got %0d want 1", cyc);
    end
    run_cmd(2'd2, 1'b1, 6'd4, 6'd9, 7'd0, 0, cyc);
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("FAIL skip_len0 latency got %0d want 1", cyc);
    end
    repeat (2) @(negedge clk);
    n = mem_diff();
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL skip_mem diff=%0d want 0", n);
    end
  endtask

  task automatic test_rotl();
    int cyc;
    logic [31:0] want;
`ifdef XOR_MAP_ROTL_EN
    want = 32'h00000018;
`else
    want = 32'h80000005;
`endif
    load(20, 32'h80000001); load(30, 32'h4);
    model_cmd(2'd3, 1'b1, 6'd20, 6'd30, 1);
    run_cmd(2'd3, 1'b1, 6'd20, 6'd30, 7'd1, 0, cyc);
    @(negedge clk);
    checks++;
    if (rf[20] !== want) begin
      failures++;
      $display("FAIL rotl got %h want %h", rf[20], want);
    end
  endtask

  task automatic test_sub_ignore();
    int cyc, n;
    model_cmd(2'd2, 1'b1, 6'd33, 6'd40, 7);
    run_cmd(2'd2, 1'b1, 6'd33, 6'd40, 7'd7, 4, cyc);
    checks++;
    if (cyc !== 9) begin
      failures++;
      $display("FAIL sub_ignore latency got %0d want 9", cyc);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    n = mem_diff();
    checks++;
    if (n !== 0 || exp_q.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sub_ignore_mem diff=%0d pending=%0d busy=%b want 0 0 0", n, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    model_cmd(2'd0, 1'b1, 6'd16, 6'd15, 2);
    @(negedge clk);
    op = 2'd0; cond_flag = 1'b1; origin = 6'd16; modifier = 6'd15;
    length = 7'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid busy=%b we=%b want 0 0", busy, rf_we);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n = mem_diff();
    checks++;
    if (n !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_mem diff=%0d pending=%0d want 0 0", n, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2, n;
    model_cmd(2'd1, 1'b1, 6'd5, 6'd4, 64);
    run_cmd(2'd1, 1'b1, 6'd5, 6'd4, 7'd64, 0, cyc1);
    model_cmd(2'd0, 1'b1, 6'd10, 6'd11, 5);
    run_cmd(2'd0, 1'b1, 6'd10, 6'd11, 7'd5, 0, cyc2);
    checks++;
    if (cyc1 !== 66 || cyc2 !== 7) begin
      failures++;
      $display("FAIL back_to_back latency got %0d %0d want 66 7", cyc1, cyc2);
    end
    @(negedge clk);
    n = mem_diff();
    checks++;
    if (n !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL back_to_back_mem diff=%0d pending=%0d want 0 0", n, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) load(6'(i), $urandom);
    test_reset();
    test_xor();
    test_overlap();
    test_add_wrap();
    test_skip();
    test_rotl();
    test_sub_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
